// File: rtl/store_align_queue_if.sv
// Store-queue bus bundle: MEM-stage request side plus memory issue side.
// The slave modport is the queue; the master modport is the pipeline/memory environment.
interface store_align_queue_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [AW-1:0]       req_addr;
    logic [XLEN-1:0]     req_data;
    logic [1:0]          req_size;
    logic                mem_valid;
    logic                mem_ready;
    logic [AW-1:0]       mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_wstrb;
    logic                misalign_err;
    logic                empty;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, misalign_err, empty
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, misalign_err, empty
    );
endinterface

// File: rtl/store_align_queue.sv
// Store byte-lane aligner feeding an in-order DEPTH-entry issue FIFO with registered mem_* outputs.
// Optional macro STORE_MISALIGN_SPLIT_EN splits lane-crossing stores into two adjacent beats.
module store_align_queue #(
    parameter int XLEN  = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    store_align_queue_if.slave bus
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]   addr_q  [DEPTH];
    logic [AW-1:0]   addr_d  [DEPTH];
    logic [XLEN-1:0] wdata_q [DEPTH];
    logic [XLEN-1:0] wdata_d [DEPTH];
    logic [NB-1:0]   wstrb_q [DEPTH];
    logic [NB-1:0]   wstrb_d [DEPTH];

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            mem_valid_q;
    logic [AW-1:0]   mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [NB-1:0]   mem_wstrb_q;
    logic            err_q, err_d;
    logic            empty_q;
    logic            req_ready_q, req_ready_d;

    logic [OW-1:0]     off_s;
    logic [3:0]        bytes_s;
    logic [2*NB-1:0]   base_mask_s;
    logic [2*NB-1:0]   wide_strb_s;
    logic [XLEN-1:0]   data_mask_s;
    logic [2*XLEN-1:0] wide_data_s;
    logic [AW-1:0]     base_addr_s;
    logic              illegal_s;
    logic              misalign_s;
    logic              accept_s;
    logic              deq_s;
    logic [1:0]        n_wr_s;

    // Lane alignment: the request is placed in a double-width window so the spill beat falls out directly.
    always_comb begin
        off_s   = bus.req_addr[OW-1:0];
        bytes_s = 4'd1 << bus.req_size;
        for (int i = 0; i < 2 * NB; i++) begin
            base_mask_s[i] = (i < int'(bytes_s));
        end
        for (int i = 0; i < XLEN; i++) begin
            data_mask_s[i] = base_mask_s[i / 8];
        end
        wide_strb_s = base_mask_s << off_s;
        wide_data_s = {{XLEN{1'b0}}, bus.req_data & data_mask_s} << {off_s, 3'b000};
        base_addr_s = {bus.req_addr[AW-1:OW], {OW{1'b0}}};
        illegal_s   = (XLEN == 32) && (bus.req_size == 2'd3);
        misalign_s  = ({{(5 - OW){1'b0}}, off_s} + {1'b0, bytes_s}) > 5'(NB);
        accept_s    = bus.req_valid && req_ready_q;
        deq_s       = mem_valid_q && bus.mem_ready;
    end

    // Entries written per accepted request and the error pulse for dropped requests.
    always_comb begin
`ifdef STORE_MISALIGN_SPLIT_EN
        if (accept_s && !illegal_s) begin
            n_wr_s = misalign_s ? 2'd2 : 2'd1;
        end else begin
            n_wr_s = 2'd0;
        end
        err_d = accept_s && illegal_s;
`else
        if (accept_s && !illegal_s && !misalign_s) begin
            n_wr_s = 2'd1;
        end else begin
            n_wr_s = 2'd0;
        end
        err_d = accept_s && (illegal_s || misalign_s);
`endif
    end

    // FIFO next state; a split store occupies two consecutive slots.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (n_wr_s != 2'd0) begin
            addr_d[wr_ptr_q]  = base_addr_s;
            wdata_d[wr_ptr_q] = wide_data_s[XLEN-1:0];
            wstrb_d[wr_ptr_q] = wide_strb_s[NB-1:0];
        end else begin
            addr_d[wr_ptr_q]  = addr_q[wr_ptr_q];
        end
        if (n_wr_s == 2'd2) begin
            addr_d[wr_ptr_q + PW'(1)]  = base_addr_s + AW'(NB);
            wdata_d[wr_ptr_q + PW'(1)] = wide_data_s[2*XLEN-1:XLEN];
            wstrb_d[wr_ptr_q + PW'(1)] = wide_strb_s[2*NB-1:NB];
        end else begin
            addr_d[wr_ptr_q + PW'(1)]  = addr_d[wr_ptr_q + PW'(1)];
        end
        rd_ptr_d = rd_ptr_q + (deq_s ? PW'(1) : PW'(0));
        wr_ptr_d = wr_ptr_q + PW'(n_wr_s);
        count_d  = count_q + CW'(n_wr_s) - (deq_s ? CW'(1) : CW'(0));
`ifdef STORE_MISALIGN_SPLIT_EN
        req_ready_d = (count_d <= CW'(DEPTH - 2));
`else
        req_ready_d = (count_d < CW'(DEPTH));
`endif
    end

    // State and registered outputs; mem_* track the head of the updated FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= {AW{1'b0}};
                wdata_q[i] <= {XLEN{1'b0}};
                wstrb_q[i] <= {NB{1'b0}};
            end
            rd_ptr_q    <= {PW{1'b0}};
            wr_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            mem_valid_q <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {XLEN{1'b0}};
            mem_wstrb_q <= {NB{1'b0}};
            err_q       <= 1'b0;
            empty_q     <= 1'b1;
            req_ready_q <= 1'b1;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            mem_valid_q <= (count_d != {CW{1'b0}});
            mem_addr_q  <= addr_d[rd_ptr_d];
            mem_wdata_q <= wdata_d[rd_ptr_d];
            mem_wstrb_q <= wstrb_d[rd_ptr_d];
            err_q       <= err_d;
            empty_q     <= (count_d == {CW{1'b0}});
            req_ready_q <= req_ready_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_wstrb    = mem_wstrb_q;
    assign bus.misalign_err = err_q;
    assign bus.empty        = empty_q;
endmodule

// File: tb/tb_store_align_queue.sv
// Bench for store_align_queue (XLEN=32, DEPTH=4): directed plan steps plus random traffic
// checked against a byte-level queue model.
module tb_store_align_queue;
    localparam int XLEN  = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int NB    = 4;
`ifdef STORE_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    beat_t q[$];
    bit    known = 1'b0;
    bit    err_exp = 1'b0;
    int    errors = 0;
    int    checks = 0;
    bit    acc;

    store_align_queue_if #(.XLEN(XLEN), .AW(AW)) bus ();

    store_align_queue #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-by-byte placement: byte k of the store goes to lane off+k, spilling into the next word.
    task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int    off;
        int    nbytes;
        int    lane;
        beat_t b0;
        beat_t b1;
        off    = int'(a % 32'd4);
        nbytes = 1 << sz;
        b0     = '{addr: a - 32'(off), wdata: 32'h0, wstrb: 4'h0};
        b1     = '{addr: a - 32'(off) + 32'd4, wdata: 32'h0, wstrb: 4'h0};
        if (sz == 2'd3) begin
            err_exp = 1'b1;
            return;
        end
        if ((off + nbytes > NB) && !SPLIT) begin
            err_exp = 1'b1;
            return;
        end
        for (int k = 0; k < nbytes; k++) begin
            lane = off + k;
            if (lane < NB) begin
                b0.wdata[8*lane +: 8] = d[8*k +: 8];
                b0.wstrb[lane]        = 1'b1;
            end else begin
                b1.wdata[8*(lane-NB) +: 8] = d[8*k +: 8];
                b1.wstrb[lane-NB]          = 1'b1;
            end
        end
        q.push_back(b0);
        if (off + nbytes > NB) q.push_back(b1);
    endtask

    // One clock: check outputs against the model, advance the clock, then update the model.
    task automatic step(output bit accepted);
        bit          exp_ready;
        bit          deq;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        accepted = 1'b0;
        deq      = 1'b0;
        a  = bus.req_addr;
        d  = bus.req_data;
        sz = bus.req_size;
        if (known) begin
            exp_ready = SPLIT ? (q.size() <= DEPTH - 2) : (q.size() < DEPTH);
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("mem_valid", 64'(bus.mem_valid), 64'(q.size() != 0));
            chk("empty", 64'(bus.empty), 64'(q.size() == 0));
            chk("misalign_err", 64'(bus.misalign_err), 64'(err_exp));
            if (q.size() != 0) begin
                chk("mem_addr", 64'(bus.mem_addr), 64'(q[0].addr));
                chk("mem_wdata", 64'(bus.mem_wdata), 64'(q[0].wdata));
                chk("mem_wstrb", 64'(bus.mem_wstrb), 64'(q[0].wstrb));
            end
            accepted = bus.req_valid && exp_ready && !rst;
            deq      = (q.size() != 0) && bus.mem_ready && !rst;
        end
        @(posedge clk);
        #1;
        err_exp = 1'b0;
        if (rst) begin
            q.delete();
            known = 1'b1;
        end else begin
            if (deq) void'(q.pop_front());
            if (accepted) model_push(a, d, sz);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_size  = sz;
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        bus.mem_ready = 1'b0;
        #1;
        rst = 1'b1;
        step(acc);
        step(acc);
        rst = 1'b0;

        // Reset state
        chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_err", 64'(bus.misalign_err), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_mem_wstrb", 64'(bus.mem_wstrb), 64'd0);

        // SB at lane 3
        bus.mem_ready = 1'b1;
        drive(1'b1, 32'h1003, 32'hAABBCCDD, 2'd0);
        step(acc);
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        chk("sb_valid", 64'(bus.mem_valid), 64'd1);
        chk("sb_addr", 64'(bus.mem_addr), 64'h1000);
        chk("sb_wdata", 64'(bus.mem_wdata), 64'hDD000000);
        chk("sb_wstrb", 64'(bus.mem_wstrb), 64'h8);
        step(acc);
        chk("sb_empty_after", 64'(bus.empty), 64'd1);

        // SH and SW
        drive(1'b1, 32'h2002, 32'h00001234, 2'd1);
        step(acc);
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        chk("sh_addr", 64'(bus.mem_addr), 64'h2000);
        chk("sh_wdata", 64'(bus.mem_wdata), 64'h12340000);
        chk("sh_wstrb", 64'(bus.mem_wstrb), 64'hC);
        step(acc);
        drive(1'b1, 32'h2004, 32'hCAFEF00D, 2'd2);
        step(acc);
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        chk("sw_addr", 64'(bus.mem_addr), 64'h2004);
        chk("sw_wdata", 64'(bus.mem_wdata), 64'hCAFEF00D);
        chk("sw_wstrb", 64'(bus.mem_wstrb), 64'hF);
        step(acc);

        // Fill with back-pressure, then drain with a fifth store held pending
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(4 * i), 32'h100 + 32'(i), 2'd2);
            step(acc);
        end
        drive(1'b1, 32'h20, 32'h55AA55AA, 2'd2);
        chk("full_ready", 64'(bus.req_ready), 64'd0);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_head", 64'(bus.mem_addr), 64'h10 + 64'(4 * i));
            step(acc);
            if (acc) begin
                chk("fifth_accept_cycle", 64'(i), 64'd1);
                drive(1'b0, 32'h0, 32'h0, 2'd0);
            end
        end
        chk("drain_empty", 64'(bus.empty), 64'd1);

        // Lane-crossing SW
        drive(1'b1, 32'h3001, 32'h11223344, 2'd2);
        step(acc);
        drive(1'b0, 32'h0, 32'h0, 2'd0);
`ifdef STORE_MISALIGN_SPLIT_EN
        chk("split_err", 64'(bus.misalign_err), 64'd0);
        chk("beat0_addr", 64'(bus.mem_addr), 64'h3000);
        chk("beat0_wdata", 64'(bus.mem_wdata), 64'h22334400);
        chk("beat0_wstrb", 64'(bus.mem_wstrb), 64'hE);
        step(acc);
        chk("beat1_addr", 64'(bus.mem_addr), 64'h3004);
        chk("beat1_wdata", 64'(bus.mem_wdata), 64'h00000011);
        chk("beat1_wstrb", 64'(bus.mem_wstrb), 64'h1);
        step(acc);
`else
        chk("mis_err", 64'(bus.misalign_err), 64'd1);
        chk("mis_valid", 64'(bus.mem_valid), 64'd0);
        step(acc);
        chk("mis_err_pulse", 64'(bus.misalign_err), 64'd0);
`endif

        // Double-size store on a 32-bit bus
        drive(1'b1, 32'h40, 32'h99887766, 2'd3);
        step(acc);
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        chk("sd_err", 64'(bus.misalign_err), 64'd1);
        chk("sd_empty", 64'(bus.empty), 64'd1);
        step(acc);
        chk("sd_err_pulse", 64'(bus.misalign_err), 64'd0);

        // Reset with queued stores
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 32'hA0 + 32'(i), 2'd2);
            step(acc);
        end
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        chk("mrst_valid", 64'(bus.mem_valid), 64'd0);
        chk("mrst_empty", 64'(bus.empty), 64'd1);
        chk("mrst_ready", 64'(bus.req_ready), 64'd1);
        bus.mem_ready = 1'b1;
        drive(1'b1, 32'h604, 32'h0BADF00D, 2'd2);
        step(acc);
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        chk("post_rst_addr", 64'(bus.mem_addr), 64'h604);
        chk("post_rst_wdata", 64'(bus.mem_wdata), 64'h0BADF00D);
        step(acc);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom(), $urandom(), 2'($urandom_range(0, 3)));
            bus.mem_ready = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 63) == 0);
            step(acc);
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        bus.mem_ready = 1'b1;
        for (int n = 0; n < 10; n++) step(acc);
        chk("final_empty", 64'(bus.empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
